// File: rtl/mem_access_pkg.sv
// Shared types for the MEM stage: memory op/size encodings, trap causes,
// FSM state encoding and small alignment helpers.
package mem_access_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP,
        ST_HOLD,
        ST_DRAIN
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_HALF: return offset[0];
            SIZE_WORD: return offset != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/mem_access_lsu_align.sv
// Combinational lane steering: store data/byte-enable placement and load
// extraction with sign/zero extension, both honouring per-access endianness.
module lsu_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        big_endian,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data
);

    logic [4:0]  shamt;
    logic [31:0] st_val;
    logic [31:0] ld_lanes;
    logic [15:0] ld_half;

    assign shamt = {offset, 3'b000};

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        st_val    = store_data;
        be        = 4'hF;
        ld_lanes  = rdata >> shamt;
        ld_half   = big_endian ? {ld_lanes[7:0], ld_lanes[15:8]} : ld_lanes[15:0];
        load_data = big_endian ? swap32(ld_lanes) : ld_lanes;

        case (size)
            SIZE_BYTE: begin
                st_val    = {24'b0, store_data[7:0]};
                be        = 4'b0001 << offset;
                load_data = {{24{~is_unsigned & ld_lanes[7]}}, ld_lanes[7:0]};
            end
            SIZE_HALF: begin
                st_val    = {16'b0, big_endian ? {store_data[7:0], store_data[15:8]}
                                               : store_data[15:0]};
                be        = 4'b0011 << offset;
                load_data = {{16{~is_unsigned & ld_half[15]}}, ld_half};
            end
            default: begin
                st_val = big_endian ? swap32(store_data) : store_data;
            end
        endcase

        wdata = st_val << shamt;
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues loads/stores over the request/grant/response data
// bus, formats data, raises alignment/access traps and stalls while outstanding.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            squash_i,
    input  logic            bubble_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [1:0]      priv_i,
    input  logic [1:0]      mem_priv_i,
    input  logic            endianness_i,
    input  logic [1:0]      mem_op_i,
    input  logic [1:0]      mem_size_i,
    input  logic            mem_unsigned_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [4:0]      dest_i,
    output logic            bubble_o,
    output logic [XLEN-1:0] pc_o,
    output logic [1:0]      priv_o,
    output logic [1:0]      mem_priv_o,
    output logic            endianness_o,
    output logic [4:0]      dest_o,
    output logic [XLEN-1:0] dest_data_o,
    output logic            stall_o,
    output logic            trap_o,
    output logic [3:0]      trap_cause_o,
    output logic [XLEN-1:0] trap_val_o,
    output logic            dbus_req_o,
    output logic            dbus_we_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic [3:0]      dbus_be_o,
    output logic [XLEN-1:0] dbus_wdata_o,
    output logic [1:0]      dbus_priv_o,
    input  logic            dbus_gnt_i,
    input  logic            dbus_rvalid_i,
    input  logic [XLEN-1:0] dbus_rdata_i,
    input  logic            dbus_err_i
);

    state_t          state, state_next;
    logic            op_valid, is_store, misaligned, issue, completing;
    logic [XLEN-1:0] fmt_wdata, fmt_load, rsp_data;
    logic [3:0]      fmt_be, fault_cause;
    logic [XLEN-1:0] hold_data, hold_val;
    logic            hold_trap;
    logic [3:0]      hold_cause;

    lsu_align u_align (
        .size        (mem_size_i),
        .big_endian  (endianness_i),
        .offset      (alu_result_i[1:0]),
        .is_unsigned (mem_unsigned_i),
        .store_data  (store_data_i),
        .rdata       (dbus_rdata_i),
        .wdata       (fmt_wdata),
        .be          (fmt_be),
        .load_data   (fmt_load)
    );

    assign op_valid    = !bubble_i && !squash_i && (mem_op_i != MEM_NONE);
    assign is_store    = mem_op_i == MEM_STORE;
    assign misaligned  = is_misaligned(mem_size_i, alu_result_i[1:0]);
    assign issue       = (state == ST_IDLE) && op_valid && !misaligned;
    // A grant and response in the same REQ cycle completes immediately.
    assign completing  = !squash_i && dbus_rvalid_i &&
                         ((state == ST_RSP) || (state == ST_REQ && dbus_gnt_i));
    assign rsp_data    = dbus_we_o ? alu_result_i : fmt_load;
    assign fault_cause = dbus_we_o ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (issue) state_next = ST_REQ;
            ST_REQ: begin
                if (squash_i)        state_next = ST_IDLE;
                else if (dbus_gnt_i) state_next = !dbus_rvalid_i ? ST_RSP
                                                : (stall_i ? ST_HOLD : ST_IDLE);
            end
            ST_RSP: begin
                if (squash_i)           state_next = dbus_rvalid_i ? ST_IDLE : ST_DRAIN;
                else if (dbus_rvalid_i) state_next = stall_i ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD:  if (!stall_i || squash_i) state_next = ST_IDLE;
            ST_DRAIN: if (dbus_rvalid_i) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Request fields are captured once at issue and stay stable until the next issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_be_o    <= 4'h0;
            dbus_wdata_o <= '0;
            dbus_priv_o  <= 2'b00;
        end else if (issue) begin
            dbus_we_o    <= is_store;
            dbus_addr_o  <= {alu_result_i[XLEN-1:2], 2'b00};
            dbus_be_o    <= fmt_be;
            dbus_wdata_o <= fmt_wdata;
            dbus_priv_o  <= mem_priv_i;
        end
    end

    // NOTE: the hold register is reset so HOLD can never expose an undefined result or trap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_val   <= '0;
            hold_trap  <= 1'b0;
            hold_cause <= 4'h0;
        end else if (completing) begin
            hold_data  <= rsp_data;
            hold_val   <= alu_result_i;
            hold_trap  <= dbus_err_i;
            hold_cause <= fault_cause;
        end
    end

    assign dbus_req_o = (state == ST_REQ) && !squash_i;

    always_comb begin
        stall_o      = 1'b0;
        trap_o       = 1'b0;
        trap_cause_o = 4'h0;
        trap_val_o   = '0;
        dest_data_o  = alu_result_i;
        case (state)
            ST_IDLE: begin
                if (op_valid && misaligned) begin
                    trap_o       = 1'b1;
                    trap_cause_o = is_store ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
                    trap_val_o   = alu_result_i;
                end else if (op_valid) begin
                    stall_o = 1'b1;
                end
            end
            ST_REQ, ST_RSP: begin
                if (completing) begin
                    dest_data_o  = rsp_data;
                    trap_o       = dbus_err_i;
                    trap_cause_o = dbus_err_i ? fault_cause : 4'h0;
                    trap_val_o   = dbus_err_i ? alu_result_i : '0;
                end else if (!squash_i) begin
                    stall_o = 1'b1;
                end
            end
            ST_HOLD: begin
                dest_data_o = hold_data;
                if (!squash_i && hold_trap) begin
                    trap_o       = 1'b1;
                    trap_cause_o = hold_cause;
                    trap_val_o   = hold_val;
                end
            end
            // The instruction now in this stage waits until the stale response is gone.
            ST_DRAIN: stall_o = 1'b1;
            default:  stall_o = 1'b0;
        endcase
    end

    assign bubble_o     = bubble_i | squash_i | stall_o | trap_o;
    assign pc_o         = pc_i;
    assign priv_o       = priv_i;
    assign mem_priv_o   = mem_priv_i;
    assign endianness_o = endianness_i;
    assign dest_o       = dest_i;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: table of single-transaction vectors plus
// directed sequences for wait states, faults, squash/drain, hold and reset.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, squash_i, bubble_i;
    logic [31:0] pc_i;
    logic [1:0]  priv_i, mem_priv_i;
    logic        endianness_i;
    logic [1:0]  mem_op_i, mem_size_i;
    logic        mem_unsigned_i;
    logic [31:0] alu_result_i, store_data_i;
    logic [4:0]  dest_i;
    logic        bubble_o;
    logic [31:0] pc_o;
    logic [1:0]  priv_o, mem_priv_o;
    logic        endianness_o;
    logic [4:0]  dest_o;
    logic [31:0] dest_data_o;
    logic        stall_o, trap_o;
    logic [3:0]  trap_cause_o;
    logic [31:0] trap_val_o;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic [1:0]  dbus_priv_o;
    logic        dbus_gnt_i, dbus_rvalid_i, dbus_err_i;
    logic [31:0] dbus_rdata_i;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .squash_i(squash_i), .bubble_i(bubble_i),
        .pc_i(pc_i), .priv_i(priv_i), .mem_priv_i(mem_priv_i), .endianness_i(endianness_i),
        .mem_op_i(mem_op_i), .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i), .dest_i(dest_i),
        .bubble_o(bubble_o), .pc_o(pc_o), .priv_o(priv_o), .mem_priv_o(mem_priv_o),
        .endianness_o(endianness_o), .dest_o(dest_o), .dest_data_o(dest_data_o),
        .stall_o(stall_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o), .trap_val_o(trap_val_o),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o), .dbus_priv_o(dbus_priv_o),
        .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
        .dbus_err_i(dbus_err_i)
    );

    int checks = 0;
    int errors = 0;
    int txn_count = 0;

    always @(posedge clk) if (dbus_req_o && dbus_gnt_i) txn_count <= txn_count + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bubble_i = 1'b1; squash_i = 1'b0; stall_i = 1'b0;
        mem_op_i = MEM_NONE; mem_size_i = SIZE_WORD; mem_unsigned_i = 1'b0;
        endianness_i = 1'b0; mem_priv_i = 2'd1;
        dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_err_i = 1'b0; dbus_rdata_i = '0;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [1:0] size, input logic big,
                            input logic [31:0] addr, input logic [31:0] sdata);
        bubble_i = 1'b0; mem_op_i = op; mem_size_i = size; endianness_i = big;
        mem_unsigned_i = 1'b0; alu_result_i = addr; store_data_i = sdata;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic        uns;
        logic        big;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        exp_trap;
        logic [3:0]  exp_cause;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    initial begin
        vec_t v;
        int   n_stall;
        int   t0;

        //            op         size       u     big   addr          sdata         rdata         be       wdata         data          trap  cause
        vecs[0]  = '{MEM_NONE,  SIZE_WORD, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0,        32'h0,        4'h0,    32'h0,        32'hDEADBEEF, 1'b0, 4'd0};
        vecs[1]  = '{MEM_LOAD,  SIZE_WORD, 1'b0, 1'b0, 32'h00000100, 32'h0,        32'h11223344, 4'hF,    32'h0,        32'h11223344, 1'b0, 4'd0};
        vecs[2]  = '{MEM_LOAD,  SIZE_BYTE, 1'b0, 1'b1, 32'h00000103, 32'h0,        32'hF0000000, 4'b1000, 32'h0,        32'hFFFFFFF0, 1'b0, 4'd0};
        vecs[3]  = '{MEM_LOAD,  SIZE_BYTE, 1'b1, 1'b0, 32'h00000101, 32'h0,        32'h0000A500, 4'b0010, 32'h0,        32'h000000A5, 1'b0, 4'd0};
        vecs[4]  = '{MEM_LOAD,  SIZE_HALF, 1'b0, 1'b0, 32'h00000102, 32'h0,        32'h80010000, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0, 4'd0};
        vecs[5]  = '{MEM_LOAD,  SIZE_HALF, 1'b0, 1'b1, 32'h00000100, 32'h0,        32'h00001234, 4'b0011, 32'h0,        32'h00003412, 1'b0, 4'd0};
        vecs[6]  = '{MEM_LOAD,  SIZE_WORD, 1'b0, 1'b1, 32'h00000200, 32'h0,        32'h11223344, 4'hF,    32'h0,        32'h44332211, 1'b0, 4'd0};
        vecs[7]  = '{MEM_LOAD,  SIZE_HALF, 1'b1, 1'b1, 32'h00000102, 32'h0,        32'h80010000, 4'b1100, 32'h0,        32'h00000180, 1'b0, 4'd0};
        vecs[8]  = '{MEM_STORE, SIZE_HALF, 1'b0, 1'b1, 32'h00000202, 32'hABCD1234, 32'h0,        4'b1100, 32'h34120000, 32'h00000202, 1'b0, 4'd0};
        vecs[9]  = '{MEM_STORE, SIZE_BYTE, 1'b0, 1'b0, 32'h00000301, 32'h000000EE, 32'h0,        4'b0010, 32'h0000EE00, 32'h00000301, 1'b0, 4'd0};
        vecs[10] = '{MEM_STORE, SIZE_WORD, 1'b0, 1'b1, 32'h00000304, 32'h01020304, 32'h0,        4'hF,    32'h04030201, 32'h00000304, 1'b0, 4'd0};
        vecs[11] = '{MEM_STORE, SIZE_WORD, 1'b0, 1'b0, 32'h00000400, 32'hCAFEF00D, 32'h0,        4'hF,    32'hCAFEF00D, 32'h00000400, 1'b0, 4'd0};
        vecs[12] = '{MEM_LOAD,  SIZE_WORD, 1'b0, 1'b0, 32'h00000102, 32'h0,        32'h0,        4'h0,    32'h0,        32'h0,        1'b1, 4'd4};
        vecs[13] = '{MEM_STORE, SIZE_HALF, 1'b0, 1'b0, 32'h00000301, 32'h0,        32'h0,        4'h0,    32'h0,        32'h0,        1'b1, 4'd6};
        vecs[14] = '{MEM_STORE, SIZE_WORD, 1'b0, 1'b0, 32'h00000203, 32'h0,        32'h0,        4'h0,    32'h0,        32'h0,        1'b1, 4'd6};
        vecs[15] = '{MEM_LOAD,  SIZE_HALF, 1'b0, 1'b1, 32'h00000105, 32'h0,        32'h0,        4'h0,    32'h0,        32'h0,        1'b1, 4'd4};

        pc_i = 32'h8000_0000; priv_i = 2'd3; dest_i = 5'd7;
        alu_result_i = '0; store_data_i = '0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", dbus_req_o, 1'b0);
        check("rst_we", dbus_we_o, 1'b0);
        check("rst_addr", dbus_addr_o, 32'h0);
        check("rst_be", dbus_be_o, 4'h0);
        check("rst_wdata", dbus_wdata_o, 32'h0);
        check("rst_priv", dbus_priv_o, 2'd0);
        check("rst_stall", stall_o, 1'b0);
        check("rst_trap", trap_o, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // A bubble carrying a load or a misaligned address does nothing.
        tick();
        mem_op_i = MEM_LOAD; mem_size_i = SIZE_WORD; alu_result_i = 32'h102;
        @(negedge clk);
        check("bubble_stall", stall_o, 1'b0);
        check("bubble_trap", trap_o, 1'b0);
        check("bubble_req", dbus_req_o, 1'b0);
        check("bubble_o_set", bubble_o, 1'b1);
        check("pass_pc", pc_o, 32'h8000_0000);
        check("pass_dest", dest_o, 5'd7);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            tick();
            dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
            start_op(v.op, v.size, v.big, v.addr, v.sdata);
            mem_unsigned_i = v.uns;
            @(negedge clk);
            if (v.exp_trap) begin
                check($sformatf("v%0d_trap", i), trap_o, 1'b1);
                check($sformatf("v%0d_cause", i), trap_cause_o, v.exp_cause);
                check($sformatf("v%0d_tval", i), trap_val_o, v.addr);
                check($sformatf("v%0d_stall", i), stall_o, 1'b0);
                check($sformatf("v%0d_req", i), dbus_req_o, 1'b0);
                tick();
                check($sformatf("v%0d_req_after", i), dbus_req_o, 1'b0);
            end else if (v.op == MEM_NONE) begin
                check($sformatf("v%0d_data", i), dest_data_o, v.exp_data);
                check($sformatf("v%0d_stall", i), stall_o, 1'b0);
                check($sformatf("v%0d_bubble", i), bubble_o, 1'b0);
            end else begin
                check($sformatf("v%0d_stall", i), stall_o, 1'b1);
                tick();
                dbus_gnt_i = 1'b1; dbus_rvalid_i = 1'b1; dbus_rdata_i = v.rdata;
                @(negedge clk);
                check($sformatf("v%0d_req", i), dbus_req_o, 1'b1);
                check($sformatf("v%0d_addr", i), dbus_addr_o, v.addr & 32'hFFFF_FFFC);
                check($sformatf("v%0d_be", i), dbus_be_o, v.exp_be);
                check($sformatf("v%0d_we", i), dbus_we_o, v.op == MEM_STORE);
                check($sformatf("v%0d_priv", i), dbus_priv_o, 2'd1);
                if (v.op == MEM_STORE) check($sformatf("v%0d_wdata", i), dbus_wdata_o, v.exp_wdata);
                check($sformatf("v%0d_data", i), dest_data_o, v.exp_data);
                check($sformatf("v%0d_done_stall", i), stall_o, 1'b0);
                check($sformatf("v%0d_done_trap", i), trap_o, 1'b0);
            end
            tick();
            idle_inputs();
        end

        // LW with two grant wait cycles and one response wait cycle.
        tick();
        start_op(MEM_LOAD, SIZE_WORD, 1'b0, 32'h100, 32'h0);
        mem_priv_i = 2'd3;
        n_stall = 0;
        @(negedge clk) n_stall += int'(stall_o);
        tick();
        @(negedge clk) n_stall += int'(stall_o);
        check("lw_req_wait", dbus_req_o, 1'b1);
        check("lw_addr_wait", dbus_addr_o, 32'h100);
        tick();
        @(negedge clk) n_stall += int'(stall_o);
        check("lw_priv", dbus_priv_o, 2'd3);
        tick(); dbus_gnt_i = 1'b1;
        @(negedge clk) n_stall += int'(stall_o);
        tick(); dbus_gnt_i = 1'b0;
        @(negedge clk) n_stall += int'(stall_o);
        check("lw_req_dropped", dbus_req_o, 1'b0);
        tick(); dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h11223344;
        @(negedge clk);
        check("lw_data", dest_data_o, 32'h11223344);
        check("lw_done_stall", stall_o, 1'b0);
        check("lw_stall_cycles", 32'(n_stall >= 3), 32'd1);
        tick(); idle_inputs();

        // SW whose response carries an access error.
        tick();
        start_op(MEM_STORE, SIZE_WORD, 1'b0, 32'h208, 32'h12345678);
        tick(); dbus_gnt_i = 1'b1;
        tick(); dbus_gnt_i = 1'b0;
        tick(); dbus_rvalid_i = 1'b1; dbus_err_i = 1'b1;
        @(negedge clk);
        check("sw_err_trap", trap_o, 1'b1);
        check("sw_err_cause", trap_cause_o, 4'd7);
        check("sw_err_tval", trap_val_o, 32'h208);
        check("sw_err_stall", stall_o, 1'b0);
        check("sw_err_bubble", bubble_o, 1'b1);
        tick(); idle_inputs();

        // Squash after grant: the late response is drained and discarded.
        tick();
        start_op(MEM_LOAD, SIZE_WORD, 1'b0, 32'h100, 32'h0);
        tick(); dbus_gnt_i = 1'b1;
        tick(); dbus_gnt_i = 1'b0; squash_i = 1'b1;
        @(negedge clk);
        check("sq_bubble", bubble_o, 1'b1);
        tick(); squash_i = 1'b0; mem_op_i = MEM_NONE; alu_result_i = 32'h777;
        @(negedge clk);
        check("drain_bubble", bubble_o, 1'b1);
        check("drain_stall", stall_o, 1'b1);
        tick(); dbus_rvalid_i = 1'b1; dbus_err_i = 1'b1; dbus_rdata_i = 32'hBADBAD00;
        @(negedge clk);
        check("drain_trap", trap_o, 1'b0);
        check("drain_rsp_bubble", bubble_o, 1'b1);
        tick(); dbus_rvalid_i = 1'b0; dbus_err_i = 1'b0;
        @(negedge clk);
        check("post_drain_bubble", bubble_o, 1'b0);
        check("post_drain_data", dest_data_o, 32'h777);
        tick(); idle_inputs();

        // Response while downstream is stalled: HOLD keeps the result, no reissue.
        tick();
        t0 = txn_count;
        start_op(MEM_LOAD, SIZE_WORD, 1'b0, 32'h100, 32'h0);
        tick(); dbus_gnt_i = 1'b1;
        tick(); dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h55667788; stall_i = 1'b1;
        @(negedge clk);
        check("hold_rsp_data", dest_data_o, 32'h55667788);
        check("hold_rsp_stall", stall_o, 1'b0);
        tick(); dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'hDEAD0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("hold_data_%0d", k), dest_data_o, 32'h55667788);
            check($sformatf("hold_req_%0d", k), dbus_req_o, 1'b0);
            check($sformatf("hold_stall_%0d", k), stall_o, 1'b0);
            if (k == 2) stall_i = 1'b0;
            tick();
        end
        idle_inputs();
        tick();
        check("hold_txn_count", txn_count - t0, 32'd1);

        // Squash while requesting withdraws the request at once.
        start_op(MEM_LOAD, SIZE_WORD, 1'b0, 32'h100, 32'h0);
        tick(); squash_i = 1'b1;
        @(negedge clk);
        check("sq_req_withdrawn", dbus_req_o, 1'b0);
        tick(); idle_inputs();
        @(negedge clk);
        check("sq_req_idle", dbus_req_o, 1'b0);
        check("sq_req_stall", stall_o, 1'b0);

        // Reset while waiting for a response.
        tick();
        start_op(MEM_LOAD, SIZE_WORD, 1'b0, 32'h100, 32'h0);
        tick(); dbus_gnt_i = 1'b1;
        tick(); dbus_gnt_i = 1'b0;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_rsp_req", dbus_req_o, 1'b0);
        check("rst_rsp_addr", dbus_addr_o, 32'h0);
        check("rst_rsp_stall", stall_o, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("rst_rsp_req_after", dbus_req_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
